// File: rtl/key_debounce_fsm_if.sv
//------------------------------------------------------------------------------
// Module      : key_debounce_fsm_if
// Description : Key front-end signal bundle: raw key in, debounced events out.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface key_debounce_fsm_if;
    logic key_n;
    logic key_valid;
    logic key_long;
    logic key_release;
    logic key_level;

    modport master (
        output key_n,
        input  key_valid,
        input  key_long,
        input  key_release,
        input  key_level
    );

    modport slave (
        input  key_n,
        output key_valid,
        output key_long,
        output key_release,
        output key_level
    );
endinterface

`default_nettype wire

// File: rtl/key_debounce_fsm.sv
//------------------------------------------------------------------------------
// Module      : key_debounce_fsm
// Description : Synchronise and debounce an active-low key; press, long-press,
//               auto-repeat and release pulses plus a debounced level.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module key_debounce_fsm #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned LONG_CYCLES     = 50000000,
    parameter int unsigned REPEAT_CYCLES   = 10000000,
    parameter bit          REPEAT_EN       = 1'b1
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    key_debounce_fsm_if.slave  bus
);

    localparam int unsigned c_DB_W   = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned c_HOLD_W = $clog2(LONG_CYCLES);
    localparam int unsigned c_REP_W  = $clog2(REPEAT_CYCLES);

    localparam logic [c_DB_W-1:0]   c_DB_LAST   = c_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(LONG_CYCLES - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_PRE  = c_HOLD_W'(LONG_CYCLES - 2);
    localparam logic [c_REP_W-1:0]  c_REP_LAST  = c_REP_W'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_DB   = 2'd1,
        PRESSED    = 2'd2,
        RELEASE_DB = 2'd3
    } state_t;

    state_t              r_state, w_state_nxt;
    logic                r_sync1, r_sync2;
    logic [c_DB_W-1:0]   r_db_cnt, w_db_nxt;
    logic [c_HOLD_W-1:0] r_hold_cnt, w_hold_nxt;
    logic [c_REP_W-1:0]  r_rep_cnt, w_rep_nxt;
    logic                r_valid, w_valid_nxt;
    logic                r_long, w_long_nxt;
    logic                r_release, w_release_nxt;
    logic                r_level, w_level_nxt;
    logic                w_pressed;

    assign w_pressed = ~r_sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_state    <= IDLE;
            r_db_cnt   <= '0;
            r_hold_cnt <= '0;
            r_rep_cnt  <= '0;
            r_valid    <= 1'b0;
            r_long     <= 1'b0;
            r_release  <= 1'b0;
            r_level    <= 1'b0;
        end else begin
            r_sync1    <= bus.key_n;
            r_sync2    <= r_sync1;
            r_state    <= w_state_nxt;
            r_db_cnt   <= w_db_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_rep_cnt  <= w_rep_nxt;
            r_valid    <= w_valid_nxt;
            r_long     <= w_long_nxt;
            r_release  <= w_release_nxt;
            r_level    <= w_level_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_db_nxt      = r_db_cnt;
        w_hold_nxt    = r_hold_cnt;
        w_rep_nxt     = r_rep_cnt;
        w_valid_nxt   = 1'b0;
        w_long_nxt    = 1'b0;
        w_release_nxt = 1'b0;
        w_level_nxt   = r_level;

        case (r_state)
            IDLE: begin
                if (w_pressed) begin
                    w_state_nxt = PRESS_DB;
                    w_db_nxt    = '0;
                end
            end

            PRESS_DB: begin
                if (!w_pressed) begin
                    w_state_nxt = IDLE;
                    w_db_nxt    = '0;
                end else if (r_db_cnt == c_DB_LAST) begin
                    w_state_nxt = PRESSED;
                    w_valid_nxt = 1'b1;
                    w_level_nxt = 1'b1;
                    w_hold_nxt  = '0;
                    w_rep_nxt   = '0;
                end else begin
                    w_db_nxt = r_db_cnt + 1'b1;
                end
            end

            PRESSED: begin
                if (!w_pressed) begin
                    w_state_nxt = RELEASE_DB;
                    w_db_nxt    = '0;
                end else if (r_hold_cnt != c_HOLD_LAST) begin
                    w_hold_nxt = r_hold_cnt + 1'b1;
                    // Repeat schedule is anchored on the long-press pulse
                    if (r_hold_cnt == c_HOLD_PRE) begin
                        w_long_nxt = 1'b1;
                        w_rep_nxt  = '0;
                    end
                end else if (REPEAT_EN) begin
                    if (r_rep_cnt == c_REP_LAST) begin
                        w_valid_nxt = 1'b1;
                        w_rep_nxt   = '0;
                    end else begin
                        w_rep_nxt = r_rep_cnt + 1'b1;
                    end
                end
            end

            RELEASE_DB: begin
                // Hold/repeat counters stay frozen so a bounce resumes the schedule
                if (w_pressed) begin
                    w_state_nxt = PRESSED;
                end else if (r_db_cnt == c_DB_LAST) begin
                    w_state_nxt   = IDLE;
                    w_level_nxt   = 1'b0;
                    w_release_nxt = 1'b1;
                    w_db_nxt      = '0;
                end else begin
                    w_db_nxt = r_db_cnt + 1'b1;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign bus.key_valid   = r_valid;
    assign bus.key_long    = r_long;
    assign bus.key_release = r_release;
    assign bus.key_level   = r_level;

endmodule

`default_nettype wire

// File: tb/tb_key_debounce_fsm.sv
//------------------------------------------------------------------------------
// Module      : tb_key_debounce_fsm
// Description : Self-checking bench for key_debounce_fsm (repeat on and off).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_key_debounce_fsm;

    localparam int c_D = 4;
    localparam int c_L = 20;
    localparam int c_R = 8;

    logic clk;
    logic rst_n;
    logic key_n;

    int checks;
    int failures;

    key_debounce_fsm_if bus0 ();
    key_debounce_fsm_if bus1 ();

    assign bus0.key_n = key_n;
    assign bus1.key_n = key_n;

    key_debounce_fsm #(
        .DEBOUNCE_CYCLES (c_D),
        .LONG_CYCLES     (c_L),
        .REPEAT_CYCLES   (c_R),
        .REPEAT_EN       (1'b1)
    ) u_dut_rep (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    key_debounce_fsm #(
        .DEBOUNCE_CYCLES (c_D),
        .LONG_CYCLES     (c_L),
        .REPEAT_CYCLES   (c_R),
        .REPEAT_EN       (1'b0)
    ) u_dut_norep (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: run-length debounce on the two-stage-delayed key
    bit m_s1, m_s2, m_level;
    int m_run, m_hold;
    bit e_valid0, e_valid1, e_long, e_rel;

    // Per-scenario pulse tallies taken from the DUT outputs
    int n_valid0, n_valid1, n_long0, n_long1, n_rel0;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1 = 1'b1; m_s2 = 1'b1; m_level = 1'b0;
        m_run = 0; m_hold = 0;
        e_valid0 = 1'b0; e_valid1 = 1'b0; e_long = 1'b0; e_rel = 1'b0;
    endtask

    task automatic model_edge(input bit k);
        bit pressed;
        if (!rst_n) begin
            model_reset();
            return;
        end
        pressed  = !m_s2;
        e_valid0 = 1'b0; e_valid1 = 1'b0; e_long = 1'b0; e_rel = 1'b0;
        if (!m_level) begin
            m_run = pressed ? m_run + 1 : 0;
            if (m_run == c_D + 1) begin
                m_level = 1'b1; m_run = 0; m_hold = 0;
                e_valid0 = 1'b1; e_valid1 = 1'b1;
            end
        end else if (pressed) begin
            if (m_run == 0) begin
                m_hold++;
                if (m_hold == c_L - 1)
                    e_long = 1'b1;
                else if (m_hold > c_L - 1 && ((m_hold - (c_L - 1)) % c_R) == 0)
                    e_valid0 = 1'b1;
            end
            m_run = 0;
        end else begin
            m_run++;
            if (m_run == c_D + 1) begin
                m_level = 1'b0; m_run = 0; e_rel = 1'b1;
            end
        end
        m_s2 = m_s1;
        m_s1 = k;
    endtask

    task automatic compare_all();
        check_eq("valid_rep",     int'(bus0.key_valid),   int'(e_valid0));
        check_eq("valid_norep",   int'(bus1.key_valid),   int'(e_valid1));
        check_eq("long_rep",      int'(bus0.key_long),    int'(e_long));
        check_eq("long_norep",    int'(bus1.key_long),    int'(e_long));
        check_eq("release_rep",   int'(bus0.key_release), int'(e_rel));
        check_eq("release_norep", int'(bus1.key_release), int'(e_rel));
        check_eq("level_rep",     int'(bus0.key_level),   int'(m_level));
        check_eq("level_norep",   int'(bus1.key_level),   int'(m_level));
        check_eq("long_valid_overlap", int'(bus0.key_long & bus0.key_valid), 0);
        n_valid0 += int'(bus0.key_valid);
        n_valid1 += int'(bus1.key_valid);
        n_long0  += int'(bus0.key_long);
        n_long1  += int'(bus1.key_long);
        n_rel0   += int'(bus0.key_release);
    endtask

    task automatic step(input logic k);
        key_n = k;
        @(posedge clk);
        model_edge(k);
        @(negedge clk);
        compare_all();
    endtask

    task automatic run(input logic k, input int n);
        for (int i = 0; i < n; i++) step(k);
    endtask

    task automatic clear_tally();
        n_valid0 = 0; n_valid1 = 0; n_long0 = 0; n_long1 = 0; n_rel0 = 0;
    endtask

    int lat;

    initial begin
        checks = 0; failures = 0;
        key_n = 1'b1;
        rst_n = 1'b0;
        model_reset();
        clear_tally();
        #2;
        check_eq("reset_valid",   int'(bus0.key_valid),   0);
        check_eq("reset_long",    int'(bus0.key_long),    0);
        check_eq("reset_release", int'(bus0.key_release), 0);
        check_eq("reset_level",   int'(bus0.key_level),   0);
        run(1'b1, 3);
        rst_n = 1'b1;
        run(1'b1, 4);

        // Clean press, with press-latency measurement
        clear_tally();
        lat = -1;
        for (int i = 1; i <= 10; i++) begin
            step(1'b0);
            if (bus0.key_valid && lat < 0) lat = i;
        end
        check_eq("press_latency", lat, c_D + 3);
        lat = -1;
        for (int i = 1; i <= 12; i++) begin
            step(1'b1);
            if (bus0.key_release && lat < 0) lat = i;
        end
        check_eq("release_latency", lat, c_D + 3);
        check_eq("clean_valid_cnt", n_valid0, 1);
        check_eq("clean_release_cnt", n_rel0, 1);

        // Press bounce
        clear_tally();
        for (int i = 0; i < 3; i++) begin
            run(1'b0, 2);
            run(1'b1, 2);
        end
        run(1'b1, 10);
        check_eq("bounce_valid_cnt", n_valid0, 0);
        check_eq("bounce_level", int'(bus0.key_level), 0);

        // Release bounce
        clear_tally();
        run(1'b0, 12);
        run(1'b1, 2);
        run(1'b0, 6);
        check_eq("relbounce_valid_cnt", n_valid0, 1);
        check_eq("relbounce_release_cnt", n_rel0, 0);
        check_eq("relbounce_level", int'(bus0.key_level), 1);
        run(1'b1, 12);

        // Long hold: press pulse, long pulse, repeats at 34/42/50/58
        clear_tally();
        run(1'b0, 60);
        run(1'b1, 12);
        check_eq("long_valid_cnt_rep", n_valid0, 5);
        check_eq("long_valid_cnt_norep", n_valid1, 1);
        check_eq("long_cnt_rep", n_long0, 1);
        check_eq("long_cnt_norep", n_long1, 1);

        // Glitch below threshold
        clear_tally();
        run(1'b0, 3);
        run(1'b1, 10);
        check_eq("glitch_valid_cnt", n_valid0 + n_long0 + n_rel0, 0);

        // Asynchronous reset while PRESSED, key held through it
        run(1'b0, 15);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_eq("async_rst_level", int'(bus0.key_level), 0);
        check_eq("async_rst_valid", int'(bus0.key_valid | bus1.key_valid), 0);
        @(negedge clk);
        run(1'b0, 3);
        rst_n = 1'b1;
        clear_tally();
        lat = -1;
        for (int i = 1; i <= 12; i++) begin
            step(1'b0);
            if (bus0.key_valid && lat < 0) lat = i;
        end
        check_eq("post_reset_latency", lat, c_D + 3);
        check_eq("post_reset_valid_cnt", n_valid0, 1);
        run(1'b1, 12);

        // Randomised bursts, including long holds with bounces
        for (int b = 0; b < 120; b++) begin
            int len;
            len = ($urandom_range(0, 5) == 0) ? $urandom_range(20, 80)
                                             : $urandom_range(1, 12);
            run(logic'($urandom_range(0, 1)), len);
        end
        run(1'b1, 12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
